sb_rr_arbiter: RTL and testbench
================================

// Module: sb_rr_arbiter
// PURPOSE
//   N-to-1 packet arbiter for switchboard streams: merges N SB RX ports (data/last/valid/ready)
//   onto one SB TX port. Selection is round-robin with packet lock: a grant holds until the beat
//   with last=1 is accepted. Sits between several QUEUE_TO_SB_SIM sources (or RTL producers) and
//   one shared datapath/SB_TO_QUEUE_SIM sink. The output is registered: one pipeline stage.
// PARAMETERS
//   N       4    number of input ports, 2..16
//   DW      256  data width in bits (bytes = DW/8)
//   IDXW    $clog2(N)  derived localparam; not user-set
// PORTS
//   clk        in   1      single clock; all logic on posedge
//   reset      in   1      asynchronous, active-high reset
//   in_data    in   N*DW   port i occupies [i*DW +: DW]
//   in_last    in   N      per-port end-of-packet flag
//   in_valid   in   N      per-port beat valid
//   in_ready   out  N      per-port beat accepted (combinational from state)
//   out_data   out  DW     registered output data
//   out_last   out  1      registered end-of-packet
//   out_valid  out  1      registered valid
//   out_ready  in   1      downstream accept
//   grant_idx  out  IDXW   currently/last granted port (debug)
// BEHAVIOUR
//   - Reset: out_valid=0, out_last=0, out_data=0, grant_idx=0, rr_ptr=0, state=IDLE.
//     While reset is asserted, in_ready=0.
//   - Transfer occurs on a channel when valid & ready are both high at posedge. Data is never
//     dropped or duplicated.
//   - Output stage: load = ~out_valid | out_ready. The stage captures the granted input beat
//     when load=1. out_valid clears when out_ready=1 and no new beat is loaded.
//     Latency: in->out is exactly 1 cycle. Full throughput: 1 beat/cycle under continuous out_ready.
//   - FSM IDLE: winner = first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... mod N.
//     Arbitration is combinational: in_ready[winner]=load in the same cycle.
//     * On transfer with last=1: stay IDLE (single-beat packet); rr_ptr <= winner+1 mod N.
//     * On transfer with last=0: go LOCK; grant_idx <= winner.
//     * If no in_valid is high: stay IDLE; all in_ready=0.
//   - FSM LOCK: in_ready[grant_idx]=load; all other in_ready=0. Other requests are ignored.
//     On transfer with last=1: go to IDLE; rr_ptr <= grant_idx+1 mod N.
//     A new packet may be granted in the very next cycle (no bubble).
//   - Back-pressure: out_ready=0 with out_valid=1 forces load=0, so every in_ready=0 and
//     state/rr_ptr hold.
//   - Wrap: rr_ptr wraps N-1 -> 0. For N not a power of 2, the pointer must never reach >=N.
//   - A granted source dropping in_valid mid-packet: the grant holds; the arbiter waits
//     indefinitely (no timeout).
//   - Reset mid-packet: in-flight beat in the output register is discarded; FSM returns to
//     IDLE; rr_ptr=0.
// CONFIGURATION
//   SB_RR_ARBITER_PKT_CNT_EN (macro):
//   - Defined: adds output pkt_cnt [N*32] and input cnt_clr [1].
//     * Counter i increments on each port-i transfer with last=1, wrapping at 2^32.
//     * cnt_clr=1 zeroes all counters synchronously; clear wins over a same-cycle increment.
//     * Counters reset to 0.
//   - Undefined: these ports and the counter logic are absent; behaviour is otherwise identical.
// STRUCTURE
//   - Package sb_arb_pkg:
//     * typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
//     * function rr_pick(req, ptr) returning index plus a found bit.
//   - Sub-module sb_out_reg:
//     * parameterised DW+1 valid/ready pipeline register with load rule as above.
//     * Reusable on other SB paths.
//   - Top: FSM, rr_ptr, grant mux (one-hot AND-OR over N*DW), optional counters.
// TESTING (bench: QUEUE_TO_SB_SIM per input, SB_TO_QUEUE_SIM on output, N=4, DW=256)
//   1. Single port 2, 3-beat packet (bytes 0x10,0x11,0x12), out_ready=1
//      -> out identical 1 cycle later; last only on beat 3; rr_ptr=3.
//   2. All 4 ports each send a 2-beat packet, all valid in cycle 0, rr_ptr=0
//      -> output order is ports 0,1,2,3; packets not interleaved; 8 beats in 8 consecutive cycles.
//   3. Port 1 mid-packet (beat 2 of 4) while ports 0,3 request
//      -> ports 0,3 in_ready stay 0 until port 1 last is accepted; next grant goes to port 3
//         (rr_ptr=2), then port 0.
//   4. out_ready toggles 1,0,0,1 during a 4-beat packet
//      -> out_data/out_valid stable while stalled; in_ready=0 during stall; all 4 beats
//         delivered in order.
//   5. Assert reset for 2 cycles during beat 2 of a port-0 packet
//      -> out_valid=0 in the cycle after reset rises; after release, a port-2 single-beat packet
//         is granted first (rr_ptr=0 scan finds port 2).
//   6. With SB_RR_ARBITER_PKT_CNT_EN: port 3 sends 5 packets, then cnt_clr is pulsed in the same
//      cycle as a sixth last
//      -> pkt_cnt[3] reads 5, then 0 after the clear.

Source files
------------

// File: rtl/sb_arb_pkg.sv
// Package for the switchboard round-robin packet arbiter.
//   arb_state_t : arbiter FSM states (IDLE = free to arbitrate, LOCK = mid-packet)
//   rr_pick_t   : result of a round-robin search (found flag + winning index)
//   rr_pick()   : round-robin search over up to ARB_MAX_N requesters
package sb_arb_pkg;

    localparam int ARB_MAX_N    = 16;
    localparam int ARB_MAX_IDXW = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                    found;
        logic [ARB_MAX_IDXW-1:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, wrapping modulo n. The loop runs from
    // the largest offset down so the smallest offset from ptr is written last
    // and therefore wins.
    function automatic rr_pick_t rr_pick(input logic [ARB_MAX_N-1:0]    req,
                                         input logic [ARB_MAX_IDXW-1:0] ptr,
                                         input int                      n);
        rr_pick_t r;
        int       k;
        r = '0;
        for (int i = ARB_MAX_N - 1; i >= 0; i--) begin
            if (i < n) begin
                k = int'(ptr) + i;
                if (k >= n) k = k - n;
                if (req[k]) begin
                    r.found = 1'b1;
                    r.idx   = ARB_MAX_IDXW'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_out_reg.sv
// Single-stage valid/ready pipeline register, reusable on any SB path.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_valid   : upstream beat present (caller only asserts it when o_load=1)
//   i_data    : upstream payload (W bits)
//   o_load    : stage can accept a beat this cycle (empty or being drained)
//   o_valid   : registered valid
//   o_data    : registered payload
//   i_ready   : downstream accept
module sb_out_reg #(
    parameter int W = 257
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_load,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_load  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // When loading with no incoming beat the valid simply drops; data is
    // left alone so it only changes on a real capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_load) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end

endmodule

// File: rtl/sb_rr_arbiter.sv
// N-to-1 switchboard packet arbiter: round-robin selection with packet lock,
// registered output (one pipeline stage).
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_data/last/valid  : N input streams, port i data at [i*DW +: DW]
//   in_ready            : per-port accept, combinational from state and load
//   out_data/last/valid : registered output stream
//   out_ready           : downstream accept
//   grant_idx           : port holding (or last holding) a multi-beat grant
// Optional feature, macro SB_RR_ARBITER_PKT_CNT_EN:
//   cnt_clr             : synchronous clear of all packet counters
//   pkt_cnt             : N x 32-bit end-of-packet counters, port i at [i*32 +: 32]
module sb_rr_arbiter
    import sb_arb_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int DW   = 256,
    localparam int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*DW-1:0] in_data,
    input  logic [N-1:0]    in_last,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] grant_idx
`ifdef SB_RR_ARBITER_PKT_CNT_EN
    ,
    input  logic            cnt_clr,
    output logic [N*32-1:0] pkt_cnt
`endif
);

    arb_state_t      r_state, w_state_nxt;
    logic [IDXW-1:0] r_rr_ptr;
    logic [IDXW-1:0] r_grant;

    rr_pick_t        w_pick;
    logic [IDXW-1:0] w_pick_idx;
    logic [IDXW-1:0] w_sel;
    logic [IDXW-1:0] w_sel_inc;
    logic            w_load;
    logic [N-1:0]    w_ready;
    logic [N-1:0]    w_take;
    logic            w_xfer;
    logic            w_xfer_last;
    logic [DW-1:0]   w_mux_data;
    logic            w_mux_last;
    logic [DW:0]     w_out;

    assign w_pick = rr_pick(ARB_MAX_N'(in_valid), ARB_MAX_IDXW'(r_rr_ptr), N);

    // Narrow the package-width index by matching against each legal port
    // number, so the result can never name a port >= N.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N; i++)
            if (w_pick.idx == ARB_MAX_IDXW'(i)) w_pick_idx = IDXW'(i);
    end

    assign w_sel     = (r_state == ARB_LOCK) ? r_grant : w_pick_idx;
    assign w_sel_inc = (w_sel == IDXW'(N - 1)) ? '0 : w_sel + 1'b1;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ARB_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_xfer && !w_xfer_last) w_state_nxt = ARB_LOCK;
            ARB_LOCK: if (w_xfer_last)            w_state_nxt = ARB_IDLE;
            default:                              w_state_nxt = ARB_IDLE;
        endcase
    end

    // FSM: outputs. In LOCK the granted port sees ready even while it has
    // dropped valid, so the grant simply waits for it.
    always_comb begin
        w_ready = '0;
        if (!reset && w_load) begin
            if (r_state == ARB_LOCK)  w_ready[r_grant]    = 1'b1;
            else if (w_pick.found)    w_ready[w_pick_idx] = 1'b1;
        end
    end

    assign in_ready    = w_ready;
    assign w_take      = w_ready & in_valid;
    assign w_xfer      = |w_take;
    assign w_xfer_last = |(w_take & in_last);

    // One-hot AND-OR data mux keyed by the accepted beat.
    always_comb begin
        w_mux_data = '0;
        w_mux_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_mux_data = w_mux_data | (in_data[i*DW +: DW] & {DW{w_take[i]}});
            w_mux_last = w_mux_last | (in_last[i] & w_take[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
        end else begin
            if (w_xfer_last) r_rr_ptr <= w_sel_inc;
            if (r_state == ARB_IDLE && w_xfer && !w_xfer_last) r_grant <= w_sel;
        end
    end

    assign grant_idx = r_grant;

    sb_out_reg #(.W(DW + 1)) u_out_reg (
        .clk     (clk),
        .rst     (reset),
        .i_valid (w_xfer),
        .i_data  ({w_mux_last, w_mux_data}),
        .o_load  (w_load),
        .o_valid (out_valid),
        .o_data  (w_out),
        .i_ready (out_ready)
    );

    assign out_last = w_out[DW];
    assign out_data = w_out[DW-1:0];

`ifdef SB_RR_ARBITER_PKT_CNT_EN
    logic [N-1:0][31:0] r_pkt_cnt;

    // Clear has priority over a same-cycle end-of-packet increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cnt_clr)                      r_pkt_cnt[i] <= '0;
                else if (w_take[i] && in_last[i]) r_pkt_cnt[i] <= r_pkt_cnt[i] + 32'd1;
            end
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_sb_rr_arbiter.sv
module tb_sb_rr_arbiter;

    localparam int N    = 4;
    localparam int DW   = 256;
    localparam int IDXW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] grant_idx;
`ifdef SB_RR_ARBITER_PKT_CNT_EN
    logic            cnt_clr;
    logic [N*32-1:0] pkt_cnt;
`endif

    sb_rr_arbiter #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_idx (grant_idx)
`ifdef SB_RR_ARBITER_PKT_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .pkt_cnt   (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t        src_q[N][$];     // beats each source still has to hand over
    beat_t        exp_q[$];        // scoreboard: expected output beat order
    int           take_q[$];       // cycle each accepted beat must appear on out
    beat_t        pend[N][$];      // packets staged for the next launch
    int           pend_len[N][$];
    logic [N-1:0] mid = '0;        // source has handed over a non-last beat
    int           m_ptr  = 0;      // reference round-robin pointer
    int           m_gidx = 0;      // reference grant of latest multi-beat packet
    int           m_cnt[N];
    int           bp_mode = 0;     // 0: always ready, 1: random, 2: pattern
    bit           gap_en  = 1'b0;
    bit           pat[$];
    int           hs_n = 0, hs_first = 0, hs_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_i(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [DW+1:0] act, input logic [DW+1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present each source's head beat; a source already inside a packet may
    // randomly pause, which must not affect arbitration order.
    task automatic drive_inputs();
        for (int p = 0; p < N; p++) begin
            if (src_q[p].size() != 0 && !(mid[p] && gap_en && $urandom_range(2) == 0)) begin
                in_valid[p]          = 1'b1;
                in_last[p]           = src_q[p][0].last;
                in_data[p*DW +: DW]  = src_q[p][0].data;
            end else begin
                in_valid[p]          = 1'b0;
                in_last[p]           = 1'b0;
                in_data[p*DW +: DW]  = '0;
            end
        end
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(9) < 7);
            default: out_ready = (pat.size() != 0) ? pat.pop_front() : 1'b1;
        endcase
    endtask

    task automatic add_pkt(input int p, input int len, input bit rnd, input logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            if (rnd) begin
                for (int k = 0; k < DW / 32; k++) b.data[k*32 +: 32] = $urandom();
                b.data[DW-1 -: 8] = 8'(p);
            end else begin
                b.data = base + DW'(i);
            end
            b.last = (i == len - 1);
            pend[p].push_back(b);
        end
        pend_len[p].push_back(len);
    endtask

    // Reference model at packet level: with every pending source requesting,
    // packets leave whole, one at a time, each from the first non-empty
    // source at or after the pointer; the pointer then moves past it.
    task automatic launch();
        bit any;
        int p, len;
        for (int q = 0; q < N; q++)
            for (int i = 0; i < pend[q].size(); i++) src_q[q].push_back(pend[q][i]);
        do begin
            any = 1'b0;
            for (int k = 0; k < N && !any; k++) begin
                p = (m_ptr + k) % N;
                if (pend_len[p].size() != 0) begin
                    any = 1'b1;
                    len = pend_len[p].pop_front();
                    for (int j = 0; j < len; j++) exp_q.push_back(pend[p].pop_front());
                    if (len > 1) m_gidx = p;
                    m_cnt[p]++;
                    m_ptr = (p + 1) % N;
                end
            end
        end while (any);
        drive_inputs();
    endtask

    task automatic wait_done(input string name);
        int  n;
        bit  empty;
        n = 0;
        while (n < 3000) begin
            @(posedge clk); #3;
            n++;
            empty = (exp_q.size() == 0) && !out_valid;
            for (int p = 0; p < N; p++) if (src_q[p].size() != 0) empty = 1'b0;
            if (empty) break;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, %0d beats still expected", name, exp_q.size());
        end
    endtask

    // Source driver: handshakes seen before an edge are retired after it.
    initial begin : drv
        logic [N-1:0] tk;
        forever begin
            @(negedge clk);
            tk = in_valid & in_ready;
            @(posedge clk); #1;
            for (int p = 0; p < N; p++) begin
                if (tk[p] && src_q[p].size() != 0) begin
                    mid[p] = !src_q[p][0].last;
                    void'(src_q[p].pop_front());
                end
            end
            drive_inputs();
        end
    end

    // Monitor: scoreboard pop on output handshake plus protocol checks.
    initial begin : mon
        bit    stall;
        beat_t sb;
        beat_t e;
        int    t;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if ($countones(in_ready) > 1) chk_i("ready_onehot", 32'(in_ready), 32'(0));
                for (int p = 0; p < N; p++)
                    if (mid[p]) chk_i("lock_excl", 32'(in_ready & ~(N'(1) << p)), 32'(0));
                if (stall)
                    chk_v("stall_hold", {out_valid, out_last, out_data}, {1'b1, sb.last, sb.data});
                if (out_valid && !out_ready)
                    chk_i("stall_ready", 32'(in_ready), 32'(0));
                if (out_valid && !stall) begin
                    if (take_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL latency: beat on output with no accepted input");
                    end else begin
                        t = take_q.pop_front();
                        chk_i("latency", 32'(cyc), 32'(t));
                    end
                end
                if (out_valid && out_ready) begin
                    hs_n++;
                    if (hs_n == 1) hs_first = cyc;
                    hs_last = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat: unexpected beat %0h last=%0b", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk_v("beat", {1'b1, out_last, out_data}, {1'b1, e.last, e.data});
                    end
                end
                if (|(in_valid & in_ready)) take_q.push_back(cyc + 1);
                stall = out_valid && !out_ready;
                sb    = {out_data, out_last};
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int p = 0; p < N; p++) m_cnt[p] = 0;
`ifdef SB_RR_ARBITER_PKT_CNT_EN
        cnt_clr = 1'b0;
`endif
        // Reset state, with a request already pending on port 1.
        @(posedge clk); #3;
        add_pkt(1, 1, 1'b1, '0);
        launch();
        @(negedge clk);
        chk_i("rst_in_ready",  32'(in_ready),  32'(0));
        chk_i("rst_out_valid", 32'(out_valid), 32'(0));
        chk_i("rst_out_last",  32'(out_last),  32'(0));
        chk_v("rst_out_data",  {2'b00, out_data}, '0);
        chk_i("rst_grant_idx", 32'(grant_idx), 32'(0));
        @(posedge clk); #3;
        reset = 1'b0;
        wait_done("rst_release");

        // Bring the pointer back to 0.
        add_pkt(3, 1, 1'b1, '0);
        launch();
        wait_done("ptr_to_0");

        // All four ports, 2-beat packets, simultaneous: back-to-back 0,1,2,3.
        for (int p = 0; p < N; p++) add_pkt(p, 2, 1'b1, '0);
        hs_n = 0;
        launch();
        wait_done("all4");
        chk_i("all4_beats", 32'(hs_n), 32'(8));
        chk_i("all4_span",  32'(hs_last - hs_first), 32'(7));
        chk_i("all4_grant", 32'(grant_idx), 32'(m_gidx));

        // Port 2, three beats 0x10..0x12.
        add_pkt(2, 3, 1'b0, DW'(8'h10));
        launch();
        wait_done("p2_3beat");
        chk_i("p2_grant", 32'(grant_idx), 32'(2));

        // Port 0 single beat moves the pointer to 1.
        add_pkt(0, 1, 1'b1, '0);
        launch();
        wait_done("p0_single");

        // Port 1 locked (with pauses) while ports 0 and 3 request: 1, 3, 0.
        gap_en = 1'b1;
        add_pkt(1, 4, 1'b1, '0);
        add_pkt(0, 2, 1'b1, '0);
        add_pkt(3, 2, 1'b1, '0);
        launch();
        wait_done("lock");
        chk_i("lock_grant", 32'(grant_idx), 32'(m_gidx));
        gap_en = 1'b0;

        // out_ready 1,0,0,1 during a 4-beat packet.
        bp_mode = 2;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        add_pkt(0, 4, 1'b1, '0);
        launch();
        wait_done("stall_pat");
        bp_mode = 0;

        // Randomized traffic, back-pressure and mid-packet pauses.
        for (int r = 0; r < 25; r++) begin
            bp_mode = int'($urandom_range(1));
            gap_en  = 1'($urandom_range(1));
            for (int p = 0; p < N; p++) begin
                n = int'($urandom_range(3));
                for (int k = 0; k < n; k++) add_pkt(p, int'($urandom_range(4, 1)), 1'b1, '0);
            end
            launch();
            wait_done("rand");
            chk_i("rand_grant", 32'(grant_idx), 32'(m_gidx));
        end
        bp_mode = 0;
        gap_en  = 1'b0;
`ifdef SB_RR_ARBITER_PKT_CNT_EN
        for (int p = 0; p < N; p++) chk_i("cnt_rand", pkt_cnt[p*32 +: 32], 32'(m_cnt[p]));
`endif

        // Reset during beat 2 of a port-0 packet.
        add_pkt(0, 4, 1'b1, '0);
        launch();
        n = 0;
        while (src_q[0].size() > 2 && n < 50) begin
            @(posedge clk); #3;
            n++;
        end
        chk_i("rst_mid_reach", 32'(src_q[0].size()), 32'(2));
        reset = 1'b1;
        for (int p = 0; p < N; p++) begin
            src_q[p].delete();
            m_cnt[p] = 0;
        end
        exp_q.delete();
        take_q.delete();
        mid    = '0;
        m_ptr  = 0;
        m_gidx = 0;
        drive_inputs();
        @(negedge clk);
        chk_i("rst_mid_valid", 32'(out_valid), 32'(0));
        chk_i("rst_mid_ready", 32'(in_ready),  32'(0));
        chk_i("rst_mid_grant", 32'(grant_idx), 32'(0));
        @(posedge clk); #3;
        @(posedge clk); #3;
        reset = 1'b0;
        add_pkt(2, 1, 1'b1, '0);
        add_pkt(3, 1, 1'b1, '0);
        launch();
        wait_done("post_reset");

`ifdef SB_RR_ARBITER_PKT_CNT_EN
        // Five packets on port 3, then a clear coinciding with a sixth last.
        for (int k = 0; k < 5; k++) add_pkt(3, 1, 1'b1, '0);
        launch();
        wait_done("cnt5");
        chk_i("cnt_p3_five", pkt_cnt[3*32 +: 32], 32'(m_cnt[3]));
        add_pkt(3, 1, 1'b1, '0);
        launch();
        cnt_clr = 1'b1;
        @(posedge clk); #3;
        cnt_clr = 1'b0;
        for (int p = 0; p < N; p++) m_cnt[p] = 0;
        wait_done("cnt_clr");
        for (int p = 0; p < N; p++) chk_i("cnt_cleared", pkt_cnt[p*32 +: 32], 32'(m_cnt[p]));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
